// File: rtl/if_id_stage_reg_pkg.sv
// Shared constants for the IF/ID boundary: stall-bus encoding, fetch bus layout,
// reset/NOP words, predecode class encodings and MIPS opcode fields.
package if_id_stage_reg_pkg;

  localparam int STALL_W      = 6;
  localparam int IF_TO_ID_WD  = 33;
  localparam int PC_W         = 32;
  localparam int INST_W       = 32;
  localparam int CTL_CLASS_WD = 3;

  // Stall-bus bit positions and levels
  localparam int   STALL_ID_BIT = 1;
  localparam int   STALL_EX_BIT = 2;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;

  localparam logic [PC_W-1:0]   ID_PC_RESET = 32'h0000_0000;
  localparam logic [INST_W-1:0] ID_NOP_INST = 32'h0000_0000;

  localparam logic [CTL_CLASS_WD-1:0] CTL_NONE = 3'b000;
  localparam logic [CTL_CLASS_WD-1:0] CTL_BR   = 3'b001;
  localparam logic [CTL_CLASS_WD-1:0] CTL_J    = 3'b010;
  localparam logic [CTL_CLASS_WD-1:0] CTL_JR   = 3'b100;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } replay_state_e;

  function automatic logic is_regimm_branch(input logic [4:0] rt);
    return (rt == RT_BLTZ) || (rt == RT_BGEZ) || (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
  endfunction

  function automatic logic is_cond_branch_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ);
  endfunction

endpackage

// File: rtl/if_id_stage_reg_predecode.sv
// mips_predecode: classifies the ID instruction as conditional branch, j/jal,
// jr/jalr or other; forced to CTL_NONE when the stage holds no instruction.
module mips_predecode
  import if_id_stage_reg_pkg::*;
(
  input  logic                    id_valid,
  input  logic [INST_W-1:0]       id_inst,
  output logic [CTL_CLASS_WD-1:0] id_ctl_class
);

  logic [5:0] opcode;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       inst_unused;

  assign opcode      = id_inst[31:26];
  assign rt          = id_inst[20:16];
  assign funct       = id_inst[5:0];
  assign inst_unused = ^{id_inst[25:21], id_inst[15:6]};

  always_comb begin
    id_ctl_class = CTL_NONE;
    if (id_valid) begin
      if (is_cond_branch_op(opcode)) begin
        id_ctl_class = CTL_BR;
      end else if (opcode == OP_REGIMM && is_regimm_branch(rt)) begin
        id_ctl_class = CTL_BR;
      end else if (opcode == OP_J || opcode == OP_JAL) begin
        id_ctl_class = CTL_J;
      end else if (opcode == OP_SPECIAL && (funct == FN_JR || funct == FN_JALR)) begin
        id_ctl_class = CTL_JR;
      end
    end
  end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID stage register with stall/bubble/flush and an instruction replay buffer.
// Optional predecode of id_inst into id_ctl_class when IF_ID_PREDECODE_EN is defined.
module if_id_stage_reg
  import if_id_stage_reg_pkg::*;
#(
  parameter logic [PC_W-1:0]   PC_RESET = ID_PC_RESET,
  parameter logic [INST_W-1:0] NOP_INST = ID_NOP_INST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic                    flush,
  input  logic [IF_TO_ID_WD-1:0]  if_to_id_bus,
  input  logic [INST_W-1:0]       inst_sram_rdata,
  output logic                    id_valid,
  output logic [PC_W-1:0]         id_pc,
  output logic [INST_W-1:0]       id_inst,
  output logic [CTL_CLASS_WD-1:0] id_ctl_class
);

  logic            if_ce;
  logic [PC_W-1:0] if_pc;
  logic            advance;
  logic            bubble;
  logic            hold_case;
  logic            kill;
  logic            stall_unused;

  assign {if_ce, if_pc} = if_to_id_bus;
  assign stall_unused   = ^{stall[5:3], stall[0]};

  assign advance   = (stall[STALL_ID_BIT] == NO_STOP);
  assign bubble    = (stall[STALL_ID_BIT] == STOP) && (stall[STALL_EX_BIT] == NO_STOP);
  assign hold_case = (stall[STALL_ID_BIT] == STOP) && (stall[STALL_EX_BIT] == STOP);
  assign kill      = rst || flush;

  // ---- p1: IF/ID stage registers ----
  logic                vld_p1;
  logic [PC_W-1:0]     pc_p1;
  logic [INST_W-1:0]   hold_inst_p1;
  replay_state_e       state_p1;
  replay_state_e       state_nxt;
  logic                capture;

  always_ff @(posedge clk) begin
    if (kill || bubble) begin
      vld_p1 <= 1'b0;
      pc_p1  <= PC_RESET;
    end else if (advance) begin
      vld_p1 <= if_ce;
      pc_p1  <= if_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= ST_RUN;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // The SRAM word for pc_p1 is only on rdata in the first stalled cycle; grab it then.
  always_comb begin
    state_nxt = state_p1;
    capture   = 1'b0;
    if (kill || !hold_case) begin
      state_nxt = ST_RUN;
    end else if (state_p1 == ST_RUN && vld_p1) begin
      state_nxt = ST_HOLD;
      capture   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      hold_inst_p1 <= inst_sram_rdata;
    end
  end

  assign id_valid = vld_p1;
  assign id_pc    = pc_p1;

  always_comb begin
    id_inst = NOP_INST;
    if (vld_p1) begin
      id_inst = (state_p1 == ST_HOLD) ? hold_inst_p1 : inst_sram_rdata;
    end
  end

`ifdef IF_ID_PREDECODE_EN
  mips_predecode u_predecode (
    .id_valid     (vld_p1),
    .id_inst      (id_inst),
    .id_ctl_class (id_ctl_class)
  );
`else
  assign id_ctl_class = CTL_NONE;
`endif

endmodule
